// File: rtl/oam_dma.sv
// oam_dma: sprite OAM DMA engine copying page P ($P00-$PFF) to $2004 on a CPU write to $4014.
// Define OAM_DMA_ODD_ALIGN_EN to add the ALIGN cycle that puts every READ on an even (odd==0) cycle.
module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_we,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_d_out,
  output logic        bus_we,
  input  logic [7:0]  bus_d_in,
  output logic        dma_active
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  state_t     r_state, w_next;
  logic [7:0] r_page, r_cnt, r_data;
  logic       r_active;
  logic       w_trig;
`ifdef OAM_DMA_ODD_ALIGN_EN
  logic       r_odd;
  always_ff @(posedge clk) r_odd <= rst ? 1'b0 : ~r_odd;
`endif
  assign w_trig     = cpu_we && cpu_addr == TRIGGER_ADDR;
  assign dma_active = r_active;
  always_comb begin
    w_next    = r_state;
    bus_addr  = cpu_addr;
    bus_d_out = cpu_d_out;
    bus_we    = 1'b0;
    case (r_state)
      IDLE: begin
        bus_we = cpu_we;
        w_next = w_trig ? HALT : IDLE;
      end
`ifdef OAM_DMA_ODD_ALIGN_EN
      HALT:  w_next = r_odd ? READ : ALIGN;
`else
      HALT:  w_next = READ;
`endif
      ALIGN: w_next = READ;
      READ: begin
        bus_addr = {r_page, r_cnt};
        w_next   = WRITE;
      end
      WRITE: begin
        bus_addr  = OAM_DATA_ADDR;
        bus_d_out = r_data;
        bus_we    = 1'b1;
        w_next    = (r_cnt == 8'hFF) ? IDLE : READ;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_page   <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_active <= w_next != IDLE;
      if (r_state == IDLE && w_trig) begin
        r_page <= cpu_d_out;
        r_cnt  <= '0;
      end
      if (r_state == READ) r_data <= bus_d_in;
      if (r_state == WRITE && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed bench for oam_dma with a memory model and a queue of expected OAM writes.
module tb_oam_dma;
  localparam logic [15:0] OAM = 16'h2004;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_d_out = '0;
  logic        cpu_we = 1'b0;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_we;
  logic [7:0]  bus_d_in;
  logic        dma_active;
  logic [7:0]  mem [65536];
  typedef struct packed {logic [15:0] src; logic [7:0] data;} exp_t;
  exp_t        q[$];
  int          n_cmp = 0, n_err = 0, n_wr = 0, act_cycles = 0;
  logic        tb_par = 1'b0;
  logic [15:0] prev_addr = '0;

  oam_dma dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out), .cpu_we(cpu_we),
    .bus_addr(bus_addr), .bus_d_out(bus_d_out), .bus_we(bus_we), .bus_d_in(bus_d_in),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;
  assign bus_d_in = mem[bus_addr];
  always @(posedge clk) tb_par <= rst ? 1'b0 : ~tb_par;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (dma_active) act_cycles++;
      if (dma_active && bus_we) begin
        n_wr++;
        chk("sb_nonempty", {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("wr_addr", {16'd0, bus_addr}, {16'd0, OAM});
          chk("wr_data", {24'd0, bus_d_out}, {24'd0, e.data});
          chk("rd_src", {16'd0, prev_addr}, {16'd0, e.src});
        end
      end else if (!dma_active) begin
        chk("pass_addr", {16'd0, bus_addr}, {16'd0, cpu_addr});
        chk("pass_data", {24'd0, bus_d_out}, {24'd0, cpu_d_out});
        chk("pass_we", {31'd0, bus_we}, {31'd0, cpu_we});
      end
    end
    prev_addr = bus_addr;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_op(input logic [15:0] a, input logic [7:0] d, input logic we);
    cpu_addr = a;
    cpu_d_out = d;
    cpu_we = we;
    cycle();
  endtask

  // Trigger on a cycle whose parity makes HALT land on the requested odd value.
  task automatic start_dma(input logic [7:0] p, input logic halt_odd);
    while (tb_par !== ~halt_odd) cycle();
    for (int k = 0; k < 256; k++) q.push_back({{p, 8'(k)}, mem[{p, 8'(k)}]});
    act_cycles = 0;
    cpu_op(16'h4014, p, 1'b1);
    cpu_addr = 16'h0001;
    cpu_d_out = 8'h00;
    cpu_we = 1'b0;
  endtask

  task automatic finish_dma(input string tag, input int exp_len, input int wr0);
    int n = 0;
    while (dma_active !== 1'b0 && n < 600) begin
      cycle();
      n++;
    end
    chk({tag, "_timeout"}, {31'd0, n < 600}, 32'd1);
    chk({tag, "_len"}, act_cycles, exp_len);
    chk({tag, "_writes"}, n_wr - wr0, 256);
    chk({tag, "_sb_left"}, q.size(), 0);
    repeat (4) cycle();
  endtask

  initial begin
    int wr0, n;
    int len_even;
`ifdef OAM_DMA_ODD_ALIGN_EN
    len_even = 514;
`else
    len_even = 513;
`endif
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 256; k++) mem[16'h0200 + k] = 8'(k) ^ 8'h5A;
    repeat (3) cycle();
    rst = 1'b0;
    chk("reset_active", {31'd0, dma_active}, 32'd0);
    cpu_op(16'h0000, 8'h11, 1'b1);
    cpu_op(16'h0000, 8'h22, 1'b0);
    cpu_op(16'h2004, 8'h77, 1'b1);
    cpu_op(16'h2004, 8'h00, 1'b0);
    cpu_op(16'h4013, 8'h05, 1'b1);
    cpu_op(16'h4014, 8'h09, 1'b0);
    cpu_op(16'h0000, 8'h00, 1'b0);
    chk("idle_active", {31'd0, dma_active}, 32'd0);
    chk("idle_no_dma_writes", n_wr, 0);

    wr0 = n_wr;
    start_dma(8'h02, 1'b1);
    chk("halt_active", {31'd0, dma_active}, 32'd1);
    finish_dma("p02_odd", 513, wr0);

    wr0 = n_wr;
    start_dma(8'h02, 1'b0);
    finish_dma("p02_even", len_even, wr0);

    wr0 = n_wr;
    start_dma(8'hFF, 1'b1);
    finish_dma("pFF", 513, wr0);
    chk("pFF_idle", {31'd0, dma_active}, 32'd0);

    wr0 = n_wr;
    start_dma(8'h02, 1'b0);
    repeat (10) cycle();
    repeat (5) cpu_op(16'h4014, 8'h03, 1'b1);
    cpu_op(16'h0001, 8'h00, 1'b0);
    finish_dma("retrig", len_even, wr0);

    wr0 = n_wr;
    start_dma(8'h02, 1'b1);
    n = 0;
    while (n_wr - wr0 < 100 && n < 400) begin
      cycle();
      n++;
    end
    chk("rst_reach100", n_wr - wr0, 100);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    q.delete();
    chk("rst_active", {31'd0, dma_active}, 32'd0);
    repeat (20) cycle();
    chk("rst_no_more_writes", n_wr - wr0, 100);
    chk("rst_still_idle", {31'd0, dma_active}, 32'd0);

    wr0 = n_wr;
    start_dma(8'h02, 1'b1);
    finish_dma("after_rst", 513, wr0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
